store_align_unit: RTL and testbench
===================================

# store_align_unit

Store-path counterpart to the load-extension logic in the MEM stage. Accepts one store request per handshake (SB/SH/SW, byte address, register data) and issues word-aligned write beats with per-byte strobes to data memory. A valid/ready handshake runs on both sides. Optionally, misaligned stores that cross a word boundary are split into two beats. Sits between the EX/MEM pipeline register and the data memory write port, and drives a stall to the hazard unit.

## Interface
- `ADDR_W`, default 32: byte-address width. Data width is fixed at 32.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_funct3` in 3: 000 SB, 001 SH, 010 SW; other codes are illegal.
- `req_addr` in ADDR_W: byte address.
- `req_data` in 32: rs2 value; the low byte/half is used for SB/SH.
- `mem_wvalid` out 1: write beat valid.
- `mem_wready` in 1: memory accepts the beat.
- `mem_waddr` out ADDR_W: word-aligned address, bits [1:0] always 00.
- `mem_wdata` out 32: lane-shifted write data.
- `mem_wstrb` out 4: byte enables; bit i enables byte lane i.
- `busy` out 1: a beat is pending (state ≠ IDLE); used for the pipeline stall.
- `store_fault` out 1: one-cycle pulse for an illegal or rejected request.

## Operation
- States are IDLE, BEAT0 and BEAT1.
- Handshake
  - `req_ready` = (state==IDLE) || (state is on its final beat && `mem_wready`).
  - A request is accepted when `req_valid && req_ready`.
- Lane math, done on acceptance:
  - Base mask: SB 0001, SH 0011, SW 1111.
  - 64-bit data = {32'b0, data} << (8·addr[1:0]).
  - 8-bit strobe = mask << addr[1:0].
- Beats
  - BEAT0 uses address {addr[ADDR_W-1:2],2'b00}, the low data word and strb[3:0].
  - If strb[7:4]≠0, BEAT1 follows using address (BEAT0 address + 4, with modulo 2^ADDR_W wrap), the high data word and strb[7:4].
- Transitions
  - IDLE→BEAT0 on acceptance.
  - BEAT0→BEAT1 on `mem_wready` when a second beat is needed.
  - The final beat goes to BEAT0 on `mem_wready` if a new request is accepted in the same cycle. Otherwise it goes to IDLE.
- Illegal `funct3`
  - Accepted, then `store_fault` pulses the next cycle.
  - No beat is issued and the state stays or returns to IDLE.
- While `mem_wvalid && !mem_wready`, `mem_waddr`, `mem_wdata` and `mem_wstrb` are held stable.

## Timing
- Reset values:
  - `mem_wvalid`, `mem_waddr`, `mem_wdata`, `mem_wstrb`, `store_fault`, `busy` are 0.
  - `req_ready` is 1.
  - State is IDLE.
- Latency: a request accepted in cycle N gives `mem_wvalid` high in cycle N+1. All memory-side outputs are registered.
- Throughput: aligned stores with `mem_wready` held high run at 1 per cycle. Split stores take 2 cycles each.
- A fault pulse is issued in cycle N+1; `req_ready` stays 1.
- Reset asserted mid-operation, including with BEAT1 pending:
  - The pending beat is dropped.
  - `mem_wvalid` falls asynchronously.
  - No partial replay after release.

## Configuration
- `MISALIGNED_SPLIT_EN` defined:
  - Any address is legal.
  - Crossing stores (SH at offset 11, SW at offset ≠00) issue two beats.
  - Non-crossing misaligned SH (offset 01) issues a single beat with strobe 0110.
- `MISALIGNED_SPLIT_EN` undefined:
  - SH with addr[0]=1, or SW with addr[1:0]≠00, is treated as a fault: `store_fault` pulses and no beat is issued.
  - BEAT1 is unreachable and its state logic is compiled out.

## Structure
- Shared package `riscv_pkg` holds:
  - the `funct3` store constants `STORE_SB`, `STORE_SH`, `STORE_SW`;
  - the state encoding;
  - the base-mask constants.
- Sub-module `store_lane_shift` is the combinational shifter: `funct3` + addr[1:0] + data → 64-bit data, 8-bit strobe, `needs_split` and `illegal` flags. It is instantiated once.

## Test plan
- SW, addr 0x100, data 0xDEADBEEF, `mem_wready`=1 → next cycle: waddr 0x100, wdata 0xDEADBEEF, wstrb 1111, exactly one beat.
- SB, addr 0x103, data 0x000000AB → waddr 0x100, wdata 0xAB000000, wstrb 1000.
- SH, addr 0x206, data 0x1234, `mem_wready` low for 3 cycles → outputs stable for all 3 cycles with wdata 0x12340000 and wstrb 1100; `req_ready` and `busy` show the pending state; the beat completes on the 4th cycle.
- SW, addr 0x101, data 0x11223344:
  - With the macro: beat 0x100 / 0x22334400 / 1110, then beat 0x104 / 0x00000011 / 0001.
  - Without the macro: `store_fault` pulses once and `mem_wvalid` never rises.
- `funct3`=011, then SW 0x10 back-to-back → fault pulse, followed by a single beat for the SW one cycle later. Plus: SW at 0xFFFFFFFD with the macro → BEAT1 address wraps to 0x00000000.
- `rst` asserted while BEAT1 is pending → `mem_wvalid`=0 immediately; after release `req_ready`=1, `busy`=0, no replayed beat.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared store-path definitions: funct3 store codes, byte-mask constants,
// the store_align_unit state encoding and the write-beat payload type.
// No ports (package).
package riscv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    // funct3 encodings of the store instructions
    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    // Byte-enable masks before lane shifting
    localparam logic [STRB_W-1:0] MASK_SB = 4'b0001;
    localparam logic [STRB_W-1:0] MASK_SH = 4'b0011;
    localparam logic [STRB_W-1:0] MASK_SW = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } store_state_e;

    // Data/strobe half of a write beat (address is tracked separately)
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wbeat_t;

endpackage

// File: rtl/store_align_unit_if.sv
// Store request / memory write bundle for store_align_unit.
// Request side: req_valid, req_ready, req_funct3, req_addr, req_data.
// Memory side:  mem_wvalid, mem_wready, mem_waddr, mem_wdata, mem_wstrb.
// Status:       busy (pipeline stall), store_fault (one-cycle pulse).
// Modports: slave = the alignment unit, master = pipeline + memory around it.
interface store_align_unit_if
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              busy;
    logic              store_fault;

    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, mem_wready,
        output req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               busy, store_fault
    );

    modport master (
        output req_valid, req_funct3, req_addr, req_data, mem_wready,
        input  req_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wstrb,
               busy, store_fault
    );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane shifter for stores: turns funct3 + byte offset + rs2
// into a two-word data/strobe image, flags a second-word beat and flags
// requests that cannot be issued.
// Build option: MISALIGNED_SPLIT_EN -- when undefined, misaligned SH/SW
// are reported as illegal instead of being split.
// Ports: funct3, offset (addr[1:0]), data in; wide_data, wide_strb,
//        needs_split, illegal out.
module store_lane_shift
    import riscv_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          offset,
    input  logic [DATA_W-1:0]   data,
    output logic [2*DATA_W-1:0] wide_data,
    output logic [2*STRB_W-1:0] wide_strb,
    output logic                needs_split,
    output logic                illegal
);
    localparam int unsigned WIDE_DW = 2 * DATA_W;
    localparam int unsigned WIDE_SW = 2 * STRB_W;

    logic [STRB_W-1:0] mask;

    // Base mask per store size, plus legality of the request
    always_comb begin
        mask    = '0;
        illegal = 1'b0;
        case (funct3)
            STORE_SB: mask = MASK_SB;
            STORE_SH: begin
                mask = MASK_SH;
`ifndef MISALIGNED_SPLIT_EN
                illegal = offset[0];
`endif
            end
            STORE_SW: begin
                mask = MASK_SW;
`ifndef MISALIGNED_SPLIT_EN
                illegal = |offset;
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

    assign wide_data   = WIDE_DW'(data) << {offset, 3'b000};
    assign wide_strb   = WIDE_SW'(mask) << offset;
    assign needs_split = |wide_strb[WIDE_SW-1:STRB_W];

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts SB/SH/SW requests and issues word-aligned
// write beats with byte strobes; drives a stall (busy) and a fault pulse.
// Build option: MISALIGNED_SPLIT_EN -- word-crossing stores are split into
// two beats; when undefined such stores fault and BEAT1 is not built.
// Ports: clk, rst (async, active-high), bus (store_align_unit_if.slave).
module store_align_unit
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input logic              clk,
    input logic              rst,
    store_align_unit_if.slave bus
);
    logic [2*DATA_W-1:0] wide_data;
    logic [2*STRB_W-1:0] wide_strb;
    logic                needs_split;
    logic                illegal;

    store_state_e        state;
    logic                last_beat;
    logic                accept;

    logic                wvalid_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                fault_q;
    logic                busy_q;

    store_lane_shift u_lane_shift (
        .funct3      (bus.req_funct3),
        .offset      (bus.req_addr[1:0]),
        .data        (bus.req_data),
        .wide_data   (wide_data),
        .wide_strb   (wide_strb),
        .needs_split (needs_split),
        .illegal     (illegal)
    );

`ifdef MISALIGNED_SPLIT_EN
    logic   split_q;
    wbeat_t hi_beat;

    assign last_beat = (state == ST_BEAT0 && !split_q) || (state == ST_BEAT1);
`else
    // Upper word is never issued in this build
    logic unused_hi;
    assign unused_hi = ^{wide_data[2*DATA_W-1:DATA_W], wide_strb[2*STRB_W-1:STRB_W], needs_split};

    assign last_beat = (state == ST_BEAT0);
`endif

    // A new request can overlap the cycle in which the last beat retires
    assign bus.req_ready = (state == ST_IDLE) || (last_beat && bus.mem_wready);
    assign accept        = bus.req_valid && bus.req_ready;

    // State machine and registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            split_q  <= 1'b0;
            hi_beat  <= '0;
`endif
        end else begin
            fault_q <= 1'b0;
            if (accept) begin
                if (illegal) begin
                    fault_q  <= 1'b1;
                    state    <= ST_IDLE;
                    wvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end else begin
                    state    <= ST_BEAT0;
                    wvalid_q <= 1'b1;
                    busy_q   <= 1'b1;
                    waddr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                    wdata_q  <= wide_data[DATA_W-1:0];
                    wstrb_q  <= wide_strb[STRB_W-1:0];
`ifdef MISALIGNED_SPLIT_EN
                    split_q      <= needs_split;
                    hi_beat.data <= wide_data[2*DATA_W-1:DATA_W];
                    hi_beat.strb <= wide_strb[2*STRB_W-1:STRB_W];
`endif
                end
            end else if (state == ST_BEAT0 && bus.mem_wready) begin
`ifdef MISALIGNED_SPLIT_EN
                if (split_q) begin
                    // Second word wraps modulo the address space
                    state   <= ST_BEAT1;
                    split_q <= 1'b0;
                    waddr_q <= waddr_q + ADDR_W'(4);
                    wdata_q <= hi_beat.data;
                    wstrb_q <= hi_beat.strb;
                end else begin
                    state    <= ST_IDLE;
                    wvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
`else
                state    <= ST_IDLE;
                wvalid_q <= 1'b0;
                busy_q   <= 1'b0;
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            else if (state == ST_BEAT1 && bus.mem_wready) begin
                state    <= ST_IDLE;
                wvalid_q <= 1'b0;
                busy_q   <= 1'b0;
            end
`endif
        end
    end

    assign bus.mem_wvalid  = wvalid_q;
    assign bus.mem_waddr   = waddr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.store_fault = fault_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Testbench for store_align_unit: directed vector table, hand-written
// stall / back-to-back / reset sequences, and a randomized phase checked
// against a byte-level reference model. Follows MISALIGNED_SPLIT_EN.
module tb_store_align_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_align_unit_if #(.ADDR_W(32)) bus ();

    store_align_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          nbeats;
        int          nfault;
        beat_t       b0;
        beat_t       b1;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                                input int nbeats, input int nfault,
                                input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                                input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
        vec_t v;
        v.f3 = f3; v.addr = addr; v.data = data; v.nbeats = nbeats; v.nfault = nfault;
        v.b0 = {a0, d0, s0};
        v.b1 = {a1, d1, s1};
        return v;
    endfunction

    // Reference model: place each stored byte at its own address, then
    // group the bytes by the word they land in.
    function automatic void model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                                  output bit fault, output int n, output beat_t b0, output beat_t b1);
        int size;
        logic [31:0] base;
        logic [31:0] a;
        int lane;
        fault = 1'b0;
        n = 0;
        b0 = '0;
        b1 = '0;
        case (f3)
            3'b000:  size = 1;
            3'b001:  size = 2;
            3'b010:  size = 4;
            default: size = 0;
        endcase
        if (size == 0) begin
            fault = 1'b1;
            return;
        end
`ifndef MISALIGNED_SPLIT_EN
        if ((addr % 32'(size)) != 0) begin
            fault = 1'b1;
            return;
        end
`endif
        base = addr & ~32'h3;
        b0.addr = base;
        b1.addr = base + 32'd4;
        n = 1;
        for (int k = 0; k < size; k++) begin
            a = addr + 32'(k);
            lane = int'(a & 32'h3);
            if ((a & ~32'h3) == base) begin
                b0.data[lane*8 +: 8] = 8'(data >> (8 * k));
                b0.strb[lane] = 1'b1;
            end else begin
                b1.data[lane*8 +: 8] = 8'(data >> (8 * k));
                b1.strb[lane] = 1'b1;
                n = 2;
            end
        end
    endfunction

    vec_t vecs[10];

    task automatic idle_inputs();
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.mem_wready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        beat_t seen[2];
        int nseen = 0;
        int nfault = 0;
        int first = -1;
        seen[0] = '0;
        seen[1] = '0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready", idx), 96'(bus.req_ready), 96'(1));
        bus.req_valid  = 1'b1;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_data   = v.data;
        bus.mem_wready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_wvalid) begin
                if (nseen < 2) seen[nseen] = {bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb};
                if (first < 0) first = i;
                nseen++;
            end
            if (bus.store_fault) nfault++;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_nbeats", idx), 96'(nseen), 96'(v.nbeats));
        chk($sformatf("v%0d_nfault", idx), 96'(nfault), 96'(v.nfault));
        if (v.nbeats > 0) begin
            chk($sformatf("v%0d_latency", idx), 96'(first), 96'(0));
            chk($sformatf("v%0d_beat0", idx), 96'(seen[0]), 96'(v.b0));
        end
        if (v.nbeats > 1)
            chk($sformatf("v%0d_beat1", idx), 96'(seen[1]), 96'(v.b1));
    endtask

    initial begin
        beat_t exp_q[$];
        bit    fault_pending;
        bit    m_fault;
        int    m_n;
        beat_t m_b0, m_b1;
        int    n;
        bit    exp_ready;
        int    r;

        idle_inputs();

        // Async reset: outputs clear before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_wvalid", 96'(bus.mem_wvalid), 96'(0));
        chk("rst_waddr",  96'(bus.mem_waddr),  96'(0));
        chk("rst_wdata",  96'(bus.mem_wdata),  96'(0));
        chk("rst_wstrb",  96'(bus.mem_wstrb),  96'(0));
        chk("rst_fault",  96'(bus.store_fault), 96'(0));
        chk("rst_busy",   96'(bus.busy),       96'(0));
        chk("rst_ready",  96'(bus.req_ready),  96'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed vectors: {funct3, addr, data} -> beats / fault
        vecs[0] = mk(3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 32'h0, 4'h0);
        vecs[1] = mk(3'b000, 32'h103, 32'h000000AB, 1, 0, 32'h100, 32'hAB000000, 4'b1000, 32'h0, 32'h0, 4'h0);
        vecs[2] = mk(3'b001, 32'h202, 32'h0000BEEF, 1, 0, 32'h200, 32'hBEEF0000, 4'b1100, 32'h0, 32'h0, 4'h0);
        vecs[3] = mk(3'b000, 32'h101, 32'h0000005A, 1, 0, 32'h100, 32'h00005A00, 4'b0010, 32'h0, 32'h0, 4'h0);
        vecs[4] = mk(3'b111, 32'h100, 32'h12345678, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
`ifdef MISALIGNED_SPLIT_EN
        vecs[5] = mk(3'b010, 32'h101, 32'h11223344, 2, 0, 32'h100, 32'h22334400, 4'b1110, 32'h104, 32'h00000011, 4'b0001);
        vecs[6] = mk(3'b001, 32'h301, 32'h0000A55A, 1, 0, 32'h300, 32'h00A55A00, 4'b0110, 32'h0, 32'h0, 4'h0);
        vecs[7] = mk(3'b001, 32'h303, 32'h0000CAFE, 2, 0, 32'h300, 32'hFE000000, 4'b1000, 32'h304, 32'h000000CA, 4'b0001);
        vecs[8] = mk(3'b010, 32'hFFFFFFFD, 32'hA1B2C3D4, 2, 0, 32'hFFFFFFFC, 32'hB2C3D400, 4'b1110, 32'h0, 32'h000000A1, 4'b0001);
        vecs[9] = mk(3'b010, 32'h102, 32'h55667788, 2, 0, 32'h100, 32'h77880000, 4'b1100, 32'h104, 32'h00005566, 4'b0011);
`else
        vecs[5] = mk(3'b010, 32'h101, 32'h11223344, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        vecs[6] = mk(3'b001, 32'h301, 32'h0000A55A, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        vecs[7] = mk(3'b001, 32'h303, 32'h0000CAFE, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        vecs[8] = mk(3'b010, 32'hFFFFFFFD, 32'hA1B2C3D4, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        vecs[9] = mk(3'b010, 32'h102, 32'h55667788, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
`endif
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // SH with memory back-pressure for three cycles
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h206; bus.req_data = 32'h00001234; bus.mem_wready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_wvalid", i), 96'(bus.mem_wvalid), 96'(1));
            chk($sformatf("stall%0d_beat", i), 96'({bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}),
                96'({32'h204, 32'h12340000, 4'b1100}));
            chk($sformatf("stall%0d_ready", i), 96'(bus.req_ready), 96'(0));
            chk($sformatf("stall%0d_busy", i), 96'(bus.busy), 96'(1));
            @(posedge clk); #1;
        end
        bus.mem_wready = 1'b1;
        #1;
        chk("stall_release_ready", 96'(bus.req_ready), 96'(1));
        chk("stall_release_beat", 96'({bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}),
            96'({32'h204, 32'h12340000, 4'b1100}));
        @(posedge clk); #1;
        chk("stall_done_wvalid", 96'(bus.mem_wvalid), 96'(0));
        chk("stall_done_busy", 96'(bus.busy), 96'(0));

        // Illegal funct3 followed immediately by SW
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_funct3 = 3'b011;
        bus.req_addr = 32'h40; bus.req_data = 32'h0;
        @(posedge clk); #1;
        bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_data = 32'hCAFEF00D;
        chk("b2b_fault", 96'(bus.store_fault), 96'(1));
        chk("b2b_fault_wvalid", 96'(bus.mem_wvalid), 96'(0));
        chk("b2b_fault_ready", 96'(bus.req_ready), 96'(1));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_fault_clear", 96'(bus.store_fault), 96'(0));
        chk("b2b_sw_wvalid", 96'(bus.mem_wvalid), 96'(1));
        chk("b2b_sw_beat", 96'({bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}),
            96'({32'h10, 32'hCAFEF00D, 4'b1111}));
        @(posedge clk); #1;
        chk("b2b_single_beat", 96'(bus.mem_wvalid), 96'(0));

        // Reset with a beat pending (second beat when splitting is built)
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
        bus.req_funct3 = 3'b010; bus.req_addr = 32'h101; bus.req_data = 32'h11223344;
        bus.mem_wready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        bus.mem_wready = 1'b0;
        chk("rstmid_beat1_addr", 96'(bus.mem_waddr), 96'(32'h104));
`else
        bus.req_funct3 = 3'b001; bus.req_addr = 32'h206; bus.req_data = 32'h00001234;
        bus.mem_wready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
`endif
        chk("rstmid_pending", 96'(bus.mem_wvalid), 96'(1));
        rst = 1'b1;
        #1;
        chk("rstmid_wvalid", 96'(bus.mem_wvalid), 96'(0));
        chk("rstmid_busy", 96'(bus.busy), 96'(0));
        chk("rstmid_ready", 96'(bus.req_ready), 96'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rstmid_noreplay%0d", i), 96'(bus.mem_wvalid), 96'(0));
        end

        // Randomized traffic against the byte-level model
        fault_pending = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk); #1;
            bus.req_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 15));
            bus.req_funct3 = (r == 0) ? 3'($urandom_range(3, 7)) : 3'(r % 3);
            bus.req_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : 32'($urandom);
            bus.req_data = 32'($urandom);
            if (bus.req_funct3 == 3'b000) bus.req_data = bus.req_data & 32'hFF;
            if (bus.req_funct3 == 3'b001) bus.req_data = bus.req_data & 32'hFFFF;
            bus.mem_wready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n = exp_q.size();
            exp_ready = (n == 0) || (n == 1 && bus.mem_wready);
            chk("rnd_wvalid", 96'(bus.mem_wvalid), 96'(n > 0));
            chk("rnd_busy", 96'(bus.busy), 96'(n > 0));
            chk("rnd_ready", 96'(bus.req_ready), 96'(exp_ready));
            chk("rnd_fault", 96'(bus.store_fault), 96'(fault_pending));
            if (n > 0) begin
                chk("rnd_beat", 96'({bus.mem_waddr, bus.mem_wdata, bus.mem_wstrb}), 96'(exp_q[0]));
                if (bus.mem_wready) void'(exp_q.pop_front());
            end
            fault_pending = 1'b0;
            if (bus.req_valid && exp_ready) begin
                model(bus.req_funct3, bus.req_addr, bus.req_data, m_fault, m_n, m_b0, m_b1);
                fault_pending = m_fault;
                if (m_n > 0) exp_q.push_back(m_b0);
                if (m_n > 1) exp_q.push_back(m_b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
